// File: rtl/mpsoc_instr_pkg.sv
// Shared definitions for the MPSoC instruction path (delay line, receiver, future blocks).
package mpsoc_instr_pkg;

  // RV32I canonical NOP (addi x0, x0, 0); also the reset-fill word of the delay line.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Receiver endpoint states.
  typedef enum logic [1:0] {
    PRIME,
    STREAM,
    FLUSH
  } rx_state_e;

  function automatic logic is_nop(input logic [31:0] instr);
    return instr == NOP_INSTR;
  endfunction

endpackage

// File: rtl/instr_fifo_sync.sv
// Synchronous first-word-fall-through FIFO for 32-bit instruction words.
// A push on a full FIFO lands only if a pop happens in the same cycle; clear wins over both.
module instr_fifo_sync #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [31:0]              data_in,
  output logic [31:0]              head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PtrOne  = AW'(1);
  localparam logic [AW:0]   CntOne  = (AW + 1)'(1);
  localparam logic [AW:0]   CntFull = (AW + 1)'(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_count == CntFull);
  assign empty     = (r_count == '0);
  assign w_do_pop  = pop && !empty && !clear;
  assign w_do_push = push && !clear && (!full || w_do_pop);

  assign head  = r_mem[r_rptr];
  assign count = r_count;

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PtrOne;
      if (w_do_pop)  r_rptr <= r_rptr + PtrOne;
      if (w_do_push && !w_do_pop)      r_count <= r_count + CntOne;
      else if (w_do_pop && !w_do_push) r_count <= r_count - CntOne;
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= data_in;
  end

endmodule

// File: rtl/instr_stream_receiver.sv
// Consumer endpoint of the instruction delay line: drops reset-fill words, optionally squashes
// NOP bubbles, and buffers instructions for a core behind a valid/ready handshake.
module instr_stream_receiver
  import mpsoc_instr_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned PRIME_CYCLES = 3,
  parameter int unsigned SQUASH_NOP   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            instr_in,
  input  logic                   flush,
  output logic [31:0]            instr_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   overflow,
  output logic [31:0]            rx_count
);

  localparam int unsigned PcW = (PRIME_CYCLES > 0) ? $clog2(PRIME_CYCLES + 1) : 1;
  localparam logic [PcW-1:0] PrimeLoad = PcW'(PRIME_CYCLES);
  localparam logic [PcW-1:0] PcOne     = PcW'(1);

  rx_state_e              r_state;
  rx_state_e              w_state_d;
  logic [PcW-1:0]         r_prime_cnt;
  logic [PcW-1:0]         w_prime_cnt_d;
  logic                   r_overflow;
  logic [31:0]            r_rx_count;

  logic                   w_push;
  logic                   w_pop;
  logic                   w_clear;
  logic                   w_accept;
  logic                   w_drop;
  logic [31:0]            w_head;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_full;
  logic                   w_empty;

  instr_fifo_sync #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (w_push),
    .pop     (w_pop),
    .clear   (w_clear),
    .data_in (instr_in),
    .head    (w_head),
    .count   (w_count),
    .full    (w_full),
    .empty   (w_empty)
  );

  // Next-state, prime countdown and FIFO controls; flush overrides everything this cycle.
  always_comb begin
    w_state_d     = r_state;
    w_prime_cnt_d = r_prime_cnt;
    w_push        = 1'b0;
    w_pop         = out_ready && !w_empty;
    w_clear       = 1'b0;
    unique case (r_state)
      PRIME: begin
        w_prime_cnt_d = r_prime_cnt - PcOne;
        if (r_prime_cnt == PcOne) w_state_d = STREAM;
      end
      STREAM: begin
        w_push = !((SQUASH_NOP != 0) && is_nop(instr_in));
      end
      FLUSH: begin
        w_clear       = 1'b1;
        w_pop         = 1'b0;
        w_prime_cnt_d = PrimeLoad;
        w_state_d     = PRIME;
      end
      default: begin
        w_state_d     = PRIME;
        w_prime_cnt_d = PrimeLoad;
      end
    endcase
    if (flush) begin
      w_state_d = FLUSH;
      w_push    = 1'b0;
      w_pop     = 1'b0;
    end
  end

  // A push is kept if there is room, or room is being made by a same-cycle pop.
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && w_full && !w_pop;

  // State register and prime counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= PRIME;
      r_prime_cnt <= PrimeLoad;
    end else begin
      r_state     <= w_state_d;
      r_prime_cnt <= w_prime_cnt_d;
    end
  end

  // Sticky overflow flag and received-instruction counter; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_rx_count <= '0;
    end else begin
      if (w_drop)   r_overflow <= 1'b1;
      if (w_accept) r_rx_count <= r_rx_count + 32'd1;
    end
  end

  assign instr_out = w_empty ? NOP_INSTR : w_head;
  assign out_valid = !w_empty;
  assign occupancy = w_count;
  assign overflow  = r_overflow;
  assign rx_count  = r_rx_count;

endmodule

// File: tb/tb_instr_stream_receiver.sv
// Directed self-checking bench for instr_stream_receiver (DEPTH=4, PRIME_CYCLES=3, squash on).
module tb_instr_stream_receiver;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_in;
  logic        flush;
  logic [31:0] instr_out;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  occupancy;
  logic        overflow;
  logic [31:0] rx_count;

  int n_cmp = 0;
  int n_bad = 0;

  instr_stream_receiver #(
    .DEPTH        (4),
    .PRIME_CYCLES (3),
    .SQUASH_NOP   (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .instr_in  (instr_in),
    .flush     (flush),
    .instr_out (instr_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy),
    .overflow  (overflow),
    .rx_count  (rx_count)
  );

  always #5 clk = ~clk;

  // One rising edge; outputs are then sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0; instr_in = 32'hDEAD_BEEF;
    step(); step();
    n_cmp++; if (instr_out !== NOP) begin
      n_bad++; $display("FAIL reset_instr_out got %h want %h", instr_out, NOP); end
    n_cmp++; if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (occupancy !== 3'd0) begin
      n_bad++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
    n_cmp++; if (overflow !== 1'b0) begin
      n_bad++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_cmp++; if (rx_count !== 32'd0) begin
      n_bad++; $display("FAIL reset_rx_count got %0d want 0", rx_count); end
    reset = 1'b0;
  endtask

  task automatic test_priming();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr_in = NOP; step();
      n_cmp++; if (out_valid !== 1'b0) begin
        n_bad++; $display("FAIL prime_valid[%0d] got %b want 0", i, out_valid); end
    end
    instr_in = 32'h0050_0093; step();
    n_cmp++; if (out_valid !== 1'b1) begin
      n_bad++; $display("FAIL prime_first_valid got %b want 1", out_valid); end
    n_cmp++; if (instr_out !== 32'h0050_0093) begin
      n_bad++; $display("FAIL prime_first_word got %h want 00500093", instr_out); end
    n_cmp++; if (rx_count !== 32'd1) begin
      n_bad++; $display("FAIL prime_rx_count got %0d want 1", rx_count); end
    instr_in = NOP; step();
    n_cmp++; if (occupancy !== 3'd0) begin
      n_bad++; $display("FAIL prime_pop_occupancy got %0d want 0", occupancy); end
    out_ready = 1'b0;
  endtask

  task automatic test_squash();
    out_ready = 1'b0;
    instr_in = 32'h0010_0093; step();
    instr_in = NOP;           step();
    instr_in = 32'h0020_0113; step();
    instr_in = NOP;
    n_cmp++; if (occupancy !== 3'd2) begin
      n_bad++; $display("FAIL squash_occupancy got %0d want 2", occupancy); end
    n_cmp++; if (rx_count !== 32'd3) begin
      n_bad++; $display("FAIL squash_rx_count got %0d want 3", rx_count); end
    out_ready = 1'b1;
    n_cmp++; if (instr_out !== 32'h0010_0093) begin
      n_bad++; $display("FAIL squash_first got %h want 00100093", instr_out); end
    step();
    n_cmp++; if (instr_out !== 32'h0020_0113) begin
      n_bad++; $display("FAIL squash_second got %h want 00200113", instr_out); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL squash_drained got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] w;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      instr_in = 32'hA000_0000 + 32'(i); step();
      if (i == 3) begin
        n_cmp++; if (overflow !== 1'b0) begin
          n_bad++; $display("FAIL ovf_early got %b want 0", overflow); end
      end
    end
    instr_in = NOP;
    n_cmp++; if (occupancy !== 3'd4) begin
      n_bad++; $display("FAIL ovf_occupancy got %0d want 4", occupancy); end
    n_cmp++; if (overflow !== 1'b1) begin
      n_bad++; $display("FAIL ovf_flag got %b want 1", overflow); end
    n_cmp++; if (rx_count !== 32'd7) begin
      n_bad++; $display("FAIL ovf_rx_count got %0d want 7", rx_count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = 32'hA000_0000 + 32'(i);
      n_cmp++; if (instr_out !== w) begin
        n_bad++; $display("FAIL ovf_drain[%0d] got %h want %h", i, instr_out, w); end
      step();
    end
    n_cmp++; if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL ovf_drained got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_q [4];
    exp_q[0] = 32'hB000_0001; exp_q[1] = 32'hB000_0002;
    exp_q[2] = 32'hB000_0003; exp_q[3] = 32'hE000_000E;
    reset = 1'b1; out_ready = 1'b0; step(); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      instr_in = 32'hBAD0_0000 + 32'(i); step();
      n_cmp++; if (occupancy !== 3'd0) begin
        n_bad++; $display("FAIL full_prime[%0d] got %0d want 0", i, occupancy); end
    end
    for (int i = 0; i < 4; i++) begin
      instr_in = 32'hB000_0000 + 32'(i); step();
    end
    n_cmp++; if (occupancy !== 3'd4) begin
      n_bad++; $display("FAIL full_fill got %0d want 4", occupancy); end
    out_ready = 1'b1; instr_in = 32'hE000_000E; step();
    instr_in = NOP;
    n_cmp++; if (occupancy !== 3'd4) begin
      n_bad++; $display("FAIL full_pp_occupancy got %0d want 4", occupancy); end
    n_cmp++; if (overflow !== 1'b0) begin
      n_bad++; $display("FAIL full_pp_overflow got %b want 0", overflow); end
    n_cmp++; if (rx_count !== 32'd5) begin
      n_bad++; $display("FAIL full_pp_rx_count got %0d want 5", rx_count); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (instr_out !== exp_q[i]) begin
        n_bad++; $display("FAIL full_drain[%0d] got %h want %h", i, instr_out, exp_q[i]); end
      step();
    end
    n_cmp++; if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL full_drained got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      instr_in = 32'hC000_0000 + 32'(i); step();
    end
    n_cmp++; if (occupancy !== 3'd3) begin
      n_bad++; $display("FAIL flush_pre got %0d want 3", occupancy); end
    // Flush sampled at edge t; FLUSH state at t+1, PRIME at t+2..t+4, push at t+5.
    flush = 1'b1; instr_in = 32'hF000_0000; step();
    flush = 1'b0; instr_in = 32'hF000_0001; step();
    n_cmp++; if (occupancy !== 3'd0) begin
      n_bad++; $display("FAIL flush_empty got %0d want 0", occupancy); end
    n_cmp++; if (instr_out !== NOP) begin
      n_bad++; $display("FAIL flush_instr_out got %h want %h", instr_out, NOP); end
    for (int i = 2; i < 5; i++) begin
      instr_in = 32'hF000_0000 + 32'(i); step();
      n_cmp++; if (occupancy !== 3'd0) begin
        n_bad++; $display("FAIL flush_prime[%0d] got %0d want 0", i, occupancy); end
    end
    instr_in = 32'hF000_0005; step();
    n_cmp++; if (occupancy !== 3'd1) begin
      n_bad++; $display("FAIL flush_resume_occ got %0d want 1", occupancy); end
    n_cmp++; if (instr_out !== 32'hF000_0005) begin
      n_bad++; $display("FAIL flush_resume_word got %h want f0000005", instr_out); end
    n_cmp++; if (rx_count !== 32'd9) begin
      n_bad++; $display("FAIL flush_rx_count got %0d want 9", rx_count); end
    n_cmp++; if (overflow !== 1'b0) begin
      n_bad++; $display("FAIL flush_overflow got %b want 0", overflow); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; instr_in = 32'hD000_0001; step();
    n_cmp++; if (occupancy !== 3'd2) begin
      n_bad++; $display("FAIL rmid_pre got %0d want 2", occupancy); end
    reset = 1'b1; out_ready = 1'b1; instr_in = 32'hD000_0002; step();
    n_cmp++; if (instr_out !== NOP) begin
      n_bad++; $display("FAIL rmid_instr_out got %h want %h", instr_out, NOP); end
    n_cmp++; if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rmid_out_valid got %b want 0", out_valid); end
    n_cmp++; if (occupancy !== 3'd0) begin
      n_bad++; $display("FAIL rmid_occupancy got %0d want 0", occupancy); end
    n_cmp++; if (rx_count !== 32'd0) begin
      n_bad++; $display("FAIL rmid_rx_count got %0d want 0", rx_count); end
    reset = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      instr_in = 32'hD100_0000 + 32'(i); step();
      n_cmp++; if (out_valid !== 1'b0) begin
        n_bad++; $display("FAIL rmid_prime[%0d] got %b want 0", i, out_valid); end
    end
    instr_in = 32'hD000_0003; step();
    n_cmp++; if (instr_out !== 32'hD000_0003) begin
      n_bad++; $display("FAIL rmid_resume_word got %h want d0000003", instr_out); end
    n_cmp++; if (rx_count !== 32'd1) begin
      n_bad++; $display("FAIL rmid_resume_rx got %0d want 1", rx_count); end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0; instr_in = NOP;
    test_reset();
    test_priming();
    test_squash();
    test_overflow();
    test_full_push_pop();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
